// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle control FSM and the RV32I datapath.
// Plain level signals, no valid/ready: opcode is held stable by the IR from ID onward, and every strobe is a per-cycle level.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       pc_write;
  logic       pc_writenotcond;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_halted;

  modport master (
    input  opcode, alu_bcond,
    output pc_write, pc_writenotcond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted
  );

  modport slave (
    output opcode, alu_bcond,
    input  pc_write, pc_writenotcond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted
  );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multi-cycle control FSM: steers PC, memory, IR, register file and ALU muxes.
// Memory accesses in IF and MEM are held for MEM_LATENCY cycles by a wait counter.
module multicycle_control #(
  parameter int MEM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_control_if.master         bus,
  output logic [2:0]                   debug_state_o,
  output logic [$clog2(MEM_LATENCY):0] debug_cnt_o
);
  localparam int CW = $clog2(MEM_LATENCY) + 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_BR = 3'd5, S_HALT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } cls_e;

  typedef struct packed {
    logic       is_halted;
    logic       pc_write;
    logic       pc_writenotcond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  state_e        state_q, state_d;
  cls_e          cls_q, cls_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctl_t          out_q;

  function automatic cls_e classify(logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_NONE;
    endcase
  endfunction

  function automatic ctl_t decode(state_e s, cls_e c, logic last);
    ctl_t o;
    o = '0;
    case (s)
      S_IF: begin
        o.mem_read = 1'b1;
        o.ir_write = last;
      end
      S_ID: o.alu_src_b = 2'd1;
      S_EX: begin
        case (c)
          C_R:     begin o.alu_src_a = 1'b1; o.alu_op = 2'd2; end
          C_I:     begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 2'd2; end
          C_LOAD,
          C_STORE: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
          C_BRANCH: begin
            o.alu_src_a = 1'b1; o.alu_op = 2'd1;
            o.pc_writenotcond = 1'b1; o.pc_source = 1'b1;
          end
          C_JAL,
          C_JALR: begin
            o.alu_src_a = (c == C_JALR); o.alu_src_b = 2'd2;
            o.pc_write = 1'b1; o.reg_write = 1'b1;
          end
          // Unrecognised opcodes skip to the next instruction using the PC+4 left in ALUOut.
          default: begin o.pc_write = 1'b1; o.pc_source = 1'b1; end
        endcase
      end
      S_MEM: begin
        o.i_or_d    = 1'b1;
        o.mem_read  = (c == C_LOAD);
        o.mem_write = (c == C_STORE);
      end
      S_WB: begin
        o.alu_src_b  = 2'd1;
        o.pc_write   = 1'b1;
        o.reg_write  = (c == C_R) || (c == C_I) || (c == C_LOAD);
        o.mem_to_reg = (c == C_LOAD);
      end
      S_BR: begin
        o.alu_src_b = 2'd2;
        o.pc_write  = 1'b1;
      end
      S_HALT:  o.is_halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Counter defaults to zero so every entry into IF or MEM starts a fresh access.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = '0;
    case (state_q)
      S_IF: begin
        if (cnt_q == LAST) state_d = S_ID;
        else               cnt_d   = cnt_q + ONE;
      end
      S_ID: begin
        if (bus.opcode == 7'b1110011) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EX;
          cls_d   = classify(bus.opcode);
        end
      end
      S_EX: begin
        case (cls_q)
          C_R, C_I:        state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH:        state_d = bus.alu_bcond ? S_BR : S_IF;
          default:         state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (cnt_q == LAST) state_d = S_WB;
        else               cnt_d   = cnt_q + ONE;
      end
      S_WB:    state_d = S_IF;
      S_BR:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cls_q   <= C_NONE;
      cnt_q   <= '0;
      out_q   <= decode(S_IF, C_NONE, LAST == '0);
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      out_q   <= decode(state_d, cls_d, cnt_d == LAST);
    end
  end

  assign bus.is_halted       = out_q.is_halted;
  assign bus.pc_write        = out_q.pc_write;
  assign bus.pc_writenotcond = out_q.pc_writenotcond;
  assign bus.pc_source       = out_q.pc_source;
  assign bus.i_or_d          = out_q.i_or_d;
  assign bus.mem_read        = out_q.mem_read;
  assign bus.mem_write       = out_q.mem_write;
  assign bus.ir_write        = out_q.ir_write;
  assign bus.mem_to_reg      = out_q.mem_to_reg;
  assign bus.reg_write       = out_q.reg_write;
  assign bus.alu_src_a       = out_q.alu_src_a;
  assign bus.alu_src_b       = out_q.alu_src_b;
  assign bus.alu_op          = out_q.alu_op;

  assign debug_state_o = state_q;
  assign debug_cnt_o   = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: one instance at MEM_LATENCY=1, one at 3, checked cycle by cycle
// against per-instruction control traces built from the instruction-level rules.
module tb_multicycle_control;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic       halted;
    logic       pcw;
    logic       pcwnc;
    logic       pcsrc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rw;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
  } ctl_t;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic [6:0] opc   [2];
  logic       bcond [2];
  ctl_t       obs   [2];
  logic [2:0] st0, st1;
  logic [0:0] cnt0;
  logic [2:0] cnt1;

  multicycle_control_if if0 ();
  multicycle_control_if if1 ();

  assign if0.opcode    = opc[0];
  assign if0.alu_bcond = bcond[0];
  assign if1.opcode    = opc[1];
  assign if1.alu_bcond = bcond[1];

  assign obs[0] = {if0.is_halted, if0.pc_write, if0.pc_writenotcond, if0.pc_source, if0.i_or_d,
                   if0.mem_read, if0.mem_write, if0.ir_write, if0.mem_to_reg, if0.reg_write,
                   if0.alu_src_a, if0.alu_src_b, if0.alu_op};
  assign obs[1] = {if1.is_halted, if1.pc_write, if1.pc_writenotcond, if1.pc_source, if1.i_or_d,
                   if1.mem_read, if1.mem_write, if1.ir_write, if1.mem_to_reg, if1.reg_write,
                   if1.alu_src_a, if1.alu_src_b, if1.alu_op};

  multicycle_control #(.MEM_LATENCY(1)) dut0 (
    .clk(clk), .reset(rst_n[0]), .bus(if0), .debug_state_o(st0), .debug_cnt_o(cnt0)
  );
  multicycle_control #(.MEM_LATENCY(3)) dut1 (
    .clk(clk), .reset(rst_n[1]), .bus(if1), .debug_state_o(st1), .debug_cnt_o(cnt1)
  );

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q [$];

  function automatic int state_of(input int idx);
    return (idx == 0) ? int'(st0) : int'(st1);
  endfunction

  function automatic int cnt_of(input int idx);
    return (idx == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  function automatic void push_wb(input logic rw, input logic m2r);
    ctl_t c;
    c = '0; c.b = 2'd1; c.pcw = 1'b1; c.rw = rw; c.m2r = m2r;
    exp_q.push_back(c);
  endfunction

  // Reference model: the full per-cycle control trace of one instruction at latency lat.
  function automatic void gen(input int lat, input logic [6:0] op, input logic bc, input int halt_cycles);
    ctl_t c;
    for (int i = 0; i < lat; i++) begin
      c = '0; c.mr = 1'b1; c.irw = (i == lat - 1);
      exp_q.push_back(c);
    end
    c = '0; c.b = 2'd1;
    exp_q.push_back(c);
    c = '0;
    if (op == OP_ECALL) begin
      c.halted = 1'b1;
      for (int i = 0; i < halt_cycles; i++) exp_q.push_back(c);
      return;
    end
    case (op)
      OP_R: begin
        c.a = 1'b1; c.op = 2'd2; exp_q.push_back(c);
        push_wb(1'b1, 1'b0);
      end
      OP_I: begin
        c.a = 1'b1; c.b = 2'd2; c.op = 2'd2; exp_q.push_back(c);
        push_wb(1'b1, 1'b0);
      end
      OP_LOAD, OP_STORE: begin
        c.a = 1'b1; c.b = 2'd2; exp_q.push_back(c);
        c = '0; c.iord = 1'b1; c.mr = (op == OP_LOAD); c.mw = (op == OP_STORE);
        for (int i = 0; i < lat; i++) exp_q.push_back(c);
        push_wb(op == OP_LOAD, op == OP_LOAD);
      end
      OP_BRANCH: begin
        c.a = 1'b1; c.op = 2'd1; c.pcwnc = 1'b1; c.pcsrc = 1'b1; exp_q.push_back(c);
        if (bc) begin
          c = '0; c.b = 2'd2; c.pcw = 1'b1; exp_q.push_back(c);
        end
      end
      OP_JAL, OP_JALR: begin
        c.a = (op == OP_JALR); c.b = 2'd2; c.pcw = 1'b1; c.rw = 1'b1; exp_q.push_back(c);
      end
      default: begin
        c.pcw = 1'b1; c.pcsrc = 1'b1; exp_q.push_back(c);
      end
    endcase
  endfunction

  // Driver/scoreboard: checks up to n queued cycles, one per clock, then drops the rest.
  task automatic run_cycles(input int idx, input int n, input string name);
    logic [14:0] e;
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < n) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[idx] !== e) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d got %h expected %h", name, idx, k, obs[idx], e);
      end
      k++;
      @(posedge clk);
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic run_instr(input int idx, input int lat, input logic [6:0] op, input logic bc, input string name);
    opc[idx]   = op;
    bcond[idx] = bc;
    gen(lat, op, bc, 24);
    run_cycles(idx, 1000, name);
  endtask

  task automatic check_reset_state(input int idx, input int lat, input string name);
    ctl_t c;
    c = '0; c.mr = 1'b1; c.irw = (lat == 1);
    checks++;
    if (obs[idx] !== c) begin
      errors++;
      $display("FAIL %s_outputs dut%0d got %h expected %h", name, idx, obs[idx], c);
    end
    checks++;
    if (state_of(idx) !== 0) begin
      errors++;
      $display("FAIL %s_state dut%0d got %0d expected 0", name, idx, state_of(idx));
    end
    checks++;
    if (cnt_of(idx) !== 0) begin
      errors++;
      $display("FAIL %s_counter dut%0d got %0d expected 0", name, idx, cnt_of(idx));
    end
  endtask

  task automatic test_reset();
    check_reset_state(0, 1, "reset");
    check_reset_state(1, 3, "reset");
  endtask

  task automatic test_r_type();
    run_instr(0, 1, OP_R, 1'b0, "r_type_l1");
    run_instr(0, 1, OP_I, 1'b1, "i_arith_l1");
  endtask

  task automatic test_branch();
    run_instr(0, 1, OP_BRANCH, 1'b0, "branch_not_taken");
    run_instr(0, 1, OP_BRANCH, 1'b1, "branch_taken");
  endtask

  task automatic test_store();
    run_instr(0, 1, OP_STORE, 1'b0, "store_l1");
    run_instr(0, 1, OP_JAL, 1'b0, "jal_l1");
    run_instr(0, 1, OP_JALR, 1'b1, "jalr_l1");
    run_instr(0, 1, OP_LUI, 1'b0, "other_l1");
  endtask

  task automatic test_load();
    run_instr(1, 3, OP_LOAD, 1'b0, "load_l3");
    run_instr(1, 3, OP_STORE, 1'b1, "store_l3");
  endtask

  task automatic test_halt(input int idx, input int lat);
    run_instr(idx, lat, OP_ECALL, 1'b0, "halt");
    rst_n[idx] = 1'b0;
    #1;
    check_reset_state(idx, lat, "halt_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n[idx] = 1'b1;
    run_instr(idx, lat, OP_R, 1'b0, "after_halt");
  endtask

  task automatic test_mid_reset();
    opc[1]   = OP_STORE;
    bcond[1] = 1'b0;
    gen(3, OP_STORE, 1'b0, 0);
    run_cycles(1, 6, "mid_store_pre");
    checks++;
    if (obs[1].mw !== 1'b1 || cnt_of(1) !== 1) begin
      errors++;
      $display("FAIL mid_store_mem1 got mw=%b cnt=%0d expected mw=1 cnt=1", obs[1].mw, cnt_of(1));
    end
    rst_n[1] = 1'b0;
    #1;
    check_reset_state(1, 3, "mid_reset");
    @(posedge clk);
    #1;
    check_reset_state(1, 3, "mid_reset_held");
    @(negedge clk);
    rst_n[1] = 1'b1;
    run_instr(1, 3, OP_R, 1'b0, "after_mid_reset");
  endtask

  function automatic logic known_op(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
  endfunction

  task automatic test_back_to_back(input int idx, input int lat, input int n);
    logic [6:0] tbl [7];
    logic [6:0] op;
    int r;
    tbl = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 7);
      if (r == 7) begin
        do op = 7'($urandom_range(0, 127)); while (known_op(op));
      end else begin
        op = tbl[r];
      end
      run_instr(idx, lat, op, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    opc[0] = '0; opc[1] = '0;
    bcond[0] = 1'b0; bcond[1] = 1'b0;
    #2;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();

    rst_n[0] = 1'b1;
    test_r_type();
    test_branch();
    test_store();
    test_halt(0, 1);
    test_back_to_back(0, 1, 40);
    rst_n[0] = 1'b0;

    @(negedge clk);
    rst_n[1] = 1'b1;
    test_load();
    test_back_to_back(1, 3, 30);
    test_mid_reset();
    test_halt(1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM that drives the program-counter register and the rest of the RV32I multi-cycle datapath. It produces `pc_write` / `pc_writenotcond` and the PC source select. It also produces the memory, IR, register-file and ALU steering strobes for each state. It sits between the instruction register's opcode field and the datapath muxes. Memory accesses are held for a fixed, parameterised number of cycles under an internal wait counter.

## Interface
- `MEM_LATENCY`, 1, cycles each memory access is held (≥1).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  IR[6:0], valid from ID onward.
- `alu_bcond`  in  1  branch-compare result, valid in EX of a branch.
- `pc_write`  out  1  unconditional PC load.
- `pc_writenotcond`  out  1  PC load when `alu_bcond`==0.
- `pc_source`  out  1  0 = live ALU result, 1 = ALUOut register.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load.
- `mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = rs1.
- `alu_src_b`  out  2  0 = rs2, 1 = const 4, 2 = imm; 3 is unused.
- `alu_op`  out  2  0 = add, 1 = branch compare, 2 = funct decode.
- `is_halted`  out  1  high in HALT.

## Operation
- States: IF, ID, EX, MEM, WB, BR_TAKEN, HALT. Outputs decode from state, latched opcode class and wait counter. Every output not listed for a state is 0.
- IF: `mem_read`=1, `i_or_d`=0. `ir_write`=1 only on the last wait cycle (counter == MEM_LATENCY-1). Go to ID after that cycle.
- ID: `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, so ALUOut ← PC+4.
  - ECALL (1110011) goes to HALT.
  - Everything else goes to EX.
- EX, by opcode:
  - R (0110011): a=1, b=0, op=2. Go to WB.
  - I-arith (0010011): a=1, b=2, op=2. Go to WB.
  - LOAD (0000011) / STORE (0100011): a=1, b=2, op=0. Go to MEM.
  - BRANCH (1100011): a=1, b=0, op=1, `pc_writenotcond`=1, `pc_source`=1. If `alu_bcond` go to BR_TAKEN, else go to IF.
  - JAL (1101111): a=0, b=2, op=0, `pc_write`=1, `pc_source`=0, `reg_write`=1, `mem_to_reg`=0 (rd ← PC+4). Go to IF.
  - JALR (1100111): same as JAL but a=1. Go to IF.
  - Any other opcode: `pc_write`=1, `pc_source`=1 (PC ← PC+4). Go to IF.
- MEM: `i_or_d`=1.
  - LOAD asserts `mem_read`; STORE asserts `mem_write`.
  - Strobe is held for MEM_LATENCY cycles, then go to WB.
- WB: a=0, b=1, op=0, `pc_write`=1, `pc_source`=0 (PC ← PC+4). Go to IF.
  - R / I-arith: `reg_write`=1, `mem_to_reg`=0.
  - LOAD: `reg_write`=1, `mem_to_reg`=1.
  - STORE: `reg_write`=0.
- BR_TAKEN: a=0, b=2, op=0, `pc_write`=1, `pc_source`=0 (PC ← PC+imm). Go to IF.
- HALT: absorbing state. All strobes 0, `is_halted`=1. Left only by reset.
- Opcode class is latched on the ID→EX edge and used through MEM and WB.
- Wait counter:
  - Width is ⌈log2(MEM_LATENCY)⌉+1.
  - Cleared on entry to IF and to MEM; increments while in those states.
  - Never wraps, because the state exits at MEM_LATENCY-1.

## Timing
- Reset low (asynchronous): state=IF, counter=0, latched class cleared, `is_halted`=0.
  - Outputs show IF values: `mem_read`=1, `i_or_d`=0, `ir_write`=(MEM_LATENCY==1).
- Reset release: the first rising edge after release is the first IF cycle edge.
- Reset mid-access (IF or MEM): strobes drop to IF values immediately and the counter clears. No partial write is committed after reset assertion.
- Cycles per instruction, with L = MEM_LATENCY:
  - R / I-arith: L+3.
  - LOAD: 2L+3.
  - STORE: 2L+3 (WB still updates PC).
  - Branch not taken: L+2. Branch taken: L+3.
  - JAL / JALR: L+2.
- Branch in EX: `alu_bcond` is sampled at the same edge the PC module uses it. The not-taken PC load and the go-to-IF decision are consistent in that cycle.
- `pc_write` and `pc_writenotcond` are never both 1 in the same cycle.
- `mem_read` and `mem_write` are never both 1 in the same cycle.

## Test plan
- L=1, R-type (0110011): IF, ID, EX, WB, IF. `ir_write` is high in cycle 0, `reg_write` and `pc_write` are high in cycle 3, and the next IF starts at cycle 4.
- L=3, LOAD: `mem_read` with `i_or_d`=0 for cycles 0–2 and `ir_write` only in cycle 2. `mem_read` with `i_or_d`=1 for cycles 5–7. WB in cycle 8 with `mem_to_reg`=1. CPI = 9.
- L=1, BRANCH with `alu_bcond`=0: `pc_writenotcond`=1 and `pc_source`=1 in cycle 2, IF in cycle 3. With `alu_bcond`=1: BR_TAKEN in cycle 3 with `pc_write`=1, `alu_src_b`=2, then IF in cycle 4.
- L=1, STORE: `mem_write`=1 in cycle 3 only, WB in cycle 4 with `reg_write`=0 and `pc_write`=1.
- ECALL: HALT entered after ID. `is_halted`=1 and all strobes 0 for 20+ cycles. Reset low then high returns to IF with `is_halted`=0.
- L=3, assert reset in cycle 1 of MEM for a STORE: `mem_write` drops within the same cycle, the state reads IF, and the counter restarts at 0.
